// File: rtl/acc_core_ctrl.sv
// rtl/acc_core_ctrl.sv - fetch/decode/sequencing controller for the accumulator ALU
// Optional carry chain register enabled by defining CARRY_CHAIN_EN.
module acc_core_ctrl #(
  parameter int PC_W         = 10,
  parameter int MEM_WAIT_MAX = 8
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            start,
  input  logic [8:0]      instr,
  output logic [PC_W-1:0] pc,
  input  logic            branch_en,
  input  logic            alu_sc_out,
  output logic [3:0]      alu_op,
  output logic            reg_exe,
  output logic            imm_exe,
  output logic            reg_to_acc,
  output logic            acc_to_reg,
  output logic [7:0]      imm_out,
  output logic [3:0]      reg_addr,
  output logic            sc_in,
  output logic            acc_we,
  output logic            reg_we,
  output logic            mem_re,
  output logic            mem_we,
  input  logic            mem_ack,
  output logic            done,
  output logic            err
);
  localparam int CNT_W = $clog2(MEM_WAIT_MAX) + 1;

  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_BEQ = 4'd2,  OP_SL  = 4'd3;
  localparam logic [3:0] OP_SR  = 4'd4,  OP_LW  = 4'd5,  OP_SW  = 4'd6,  OP_MOV = 4'd7;
  localparam logic [3:0] OP_ASN = 4'd8,  OP_BGE = 4'd9,  OP_BNE = 4'd10, OP_AND = 4'd11;
  localparam logic [3:0] OP_OR  = 4'd12, OP_ILL = 4'd13, OP_JMP = 4'd14, OP_HLT = 4'd15;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM_WAIT, S_HALT} state_t;

  state_t            r_state;
  logic [PC_W-1:0]   r_pc;
  logic [8:0]        r_ir;
  logic              r_done;
  logic              r_err;
  logic [CNT_W-1:0]  r_wait_cnt;

  logic [3:0]        w_op;
  logic              w_mode;
  logic [3:0]        w_lo;
  logic              w_in_exec;
  logic              w_in_mem;
  logic              w_active;
  logic              w_is_alu;
  logic              w_is_mov;
  logic              w_is_carry_op;
  logic              w_uses_operand;
  logic [PC_W-1:0]   w_jmp_off;
  logic [PC_W-1:0]   w_br_step;

  assign w_op      = r_ir[8:5];
  assign w_mode    = r_ir[4];
  assign w_lo      = r_ir[3:0];
  assign w_in_exec = (r_state == S_EXEC);
  assign w_in_mem  = (r_state == S_MEM_WAIT);
  // IR is stable through MEM_WAIT, so the decode below holds its EXEC values there
  assign w_active  = w_in_exec | w_in_mem;

  assign w_is_alu       = (w_op == OP_ADD) | (w_op == OP_SUB) | (w_op == OP_SL) | (w_op == OP_SR) |
                          (w_op == OP_ASN) | (w_op == OP_AND) | (w_op == OP_OR);
  assign w_is_mov       = (w_op == OP_MOV);
  assign w_is_carry_op  = (w_op == OP_ADD) | (w_op == OP_SUB) | (w_op == OP_SL) | (w_op == OP_SR);
  assign w_uses_operand = ~(w_is_mov | (w_op == OP_JMP) | (w_op == OP_HLT) | (w_op == OP_ILL));
  assign w_jmp_off      = {{(PC_W-5){r_ir[4]}}, r_ir[4:0]};
  assign w_br_step      = branch_en ? PC_W'(2) : PC_W'(1);

  assign pc         = r_pc;
  assign alu_op     = w_active ? w_op : 4'd0;
  assign reg_exe    = w_active & w_uses_operand & w_mode;
  assign imm_exe    = w_active & w_uses_operand & ~w_mode;
  assign reg_to_acc = w_active & w_is_mov & w_mode;
  assign acc_to_reg = w_active & w_is_mov & ~w_mode;
  assign imm_out    = w_active ? {4'd0, w_lo} : 8'd0;
  assign reg_addr   = w_active ? w_lo : 4'd0;
  assign acc_we     = (w_in_exec & (w_is_alu | (w_is_mov & w_mode))) |
                      (w_in_mem & (w_op == OP_LW) & mem_ack);
  assign reg_we     = w_in_exec & w_is_mov & ~w_mode;
  assign mem_re     = w_in_mem & (w_op == OP_LW);
  assign mem_we     = w_in_mem & (w_op == OP_SW);
  assign done       = r_done;
  assign err        = r_err;

`ifdef CARRY_CHAIN_EN
  logic r_sc;
  assign sc_in = r_sc;
`else
  logic w_unused_sc;
  assign w_unused_sc = alu_sc_out;
  assign sc_in       = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_ir       <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_wait_cnt <= '0;
`ifdef CARRY_CHAIN_EN
      r_sc       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (start) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef CARRY_CHAIN_EN
            r_sc    <= 1'b0;
`endif
          end
        end
        S_FETCH: begin
          r_ir    <= instr;
          r_state <= S_EXEC;
        end
        S_EXEC: begin
`ifdef CARRY_CHAIN_EN
          if (w_is_carry_op) r_sc <= alu_sc_out;
`endif
          case (w_op)
            OP_BEQ, OP_BGE, OP_BNE: begin
              r_pc    <= r_pc + w_br_step;
              r_state <= S_FETCH;
            end
            OP_LW, OP_SW: begin
              r_wait_cnt <= '0;
              r_state    <= S_MEM_WAIT;
            end
            OP_JMP: begin
              r_pc    <= r_pc + w_jmp_off;
              r_state <= S_FETCH;
            end
            OP_HLT: begin
              r_done  <= 1'b1;
              r_state <= S_HALT;
            end
            OP_ILL: begin
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              r_state <= S_HALT;
            end
            default: begin
              r_pc    <= r_pc + PC_W'(1);
              r_state <= S_FETCH;
            end
          endcase
        end
        S_MEM_WAIT: begin
          if (mem_ack) begin
            r_pc    <= r_pc + PC_W'(1);
            r_state <= S_FETCH;
          end else if (r_wait_cnt == CNT_W'(MEM_WAIT_MAX - 1)) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/acc_core_ctrl.md
Name: acc_core_ctrl

Overview:
- Multi-cycle fetch/decode/sequencing controller that drives the accumulator ALU. It is the initiator side of the ALU control interface.
- Latches 9-bit instructions from the instruction ROM and issues the ALU opcode, operand-select and move flags.
- Consumes the ALU's branch_en and carry-out, advances the PC with skip semantics, and handshakes LW/SW with data memory.

Parameters:
PC_W, 10, program counter width; PC wraps modulo 2^PC_W
MEM_WAIT_MAX, 8, maximum cycles in MEM_WAIT before a timeout error

Ports:
CLK  in  1  clock
Reset  in  1  synchronous, active-high reset
start  in  1  pulse: begin execution at PC 0 (honoured only in IDLE/HALT)
instr  in  9  instruction ROM data for address pc (combinational ROM)
pc  out  PC_W  program counter / ROM address
branch_en  in  1  ALU branch result (1 = skip next, pc+2)
alu_sc_out  in  1  ALU carry/shift-out
alu_op  out  4  ALU opcode
reg_exe  out  1  ALU uses register operand
imm_exe  out  1  ALU uses immediate operand
reg_to_acc  out  1  MOV direction reg->acc
acc_to_reg  out  1  MOV direction acc->reg
imm_out  out  8  zero-extended instr[3:0]
reg_addr  out  4  register file address instr[3:0]
sc_in  out  1  ALU carry/shift-in
acc_we  out  1  accumulator write strobe
reg_we  out  1  register file write strobe
mem_re  out  1  data memory read request (LW)
mem_we  out  1  data memory write request (SW)
mem_ack  in  1  data memory completion
done  out  1  halted (HALT opcode, illegal opcode, or timeout)
err  out  1  halted due to illegal opcode or memory timeout

Behaviour:
- Instruction format: [8:5] opcode, [4] mode (1 = register, 0 = immediate; for MOV 1 = reg_to_acc, 0 = acc_to_reg), [3:0] reg addr or imm4.
- Opcodes: ADD 0, SUB 1, BEQ 2, SL 3, SR 4, LW 5, SW 6, MOV 7, ASSIGN 8, BGE 9, BNE 10, AND 11, OR 12, JMP 14, HALT 15. Opcode 13 is illegal.
- JMP target: pc + sign-extended instr[4:0], modulo 2^PC_W.
- FSM states: IDLE, FETCH, EXEC, MEM_WAIT, HALT.
- Reset (and reset mid-operation, any state): state=IDLE, pc=0, IR=0, sc register=0. All strobes/flags, done and err = 0 on the same edge. alu_op=0, imm_out=0.
- IDLE: start moves to FETCH with pc=0.
- FETCH (1 cycle): IR <= instr; go to EXEC. All strobes are 0.
- EXEC (1 cycle): ALU controls decoded combinationally from IR.
  - reg_exe = mode, imm_exe = ~mode, for ops other than MOV/JMP/HALT.
  - ADD/SUB/SL/SR/ASSIGN/AND/OR: acc_we=1.
  - MOV: acc_we = reg_to_acc, reg_we = acc_to_reg.
  - Next state FETCH, pc+1.
- Branches (BEQ/BGE/BNE) in EXEC: pc <= pc + (branch_en ? 2 : 1). No write strobes.
- JMP: pc <= target. HALT: go to HALT, done=1. Illegal: go to HALT, done=1, err=1, no strobes.
- LW/SW in EXEC: go to MEM_WAIT. mem_re/mem_we assert from the first MEM_WAIT cycle and hold until mem_ack.
- MEM_WAIT, mem_ack cycle: LW pulses acc_we; pc+1; go to FETCH.
- MEM_WAIT timeout: after MEM_WAIT_MAX cycles without mem_ack, go to HALT with err=1 and drop mem_re/mem_we.
- ALU control outputs hold their EXEC values through MEM_WAIT.
- HALT: done/err held. start clears done/err, pc=0, goes to FETCH.
- start outside IDLE/HALT is ignored.
- pc wraps: max+1 = 0, max+2 = 1.

Optional Feature:
- Macro CARRY_CHAIN_EN.
- Defined: an internal sc register loads alu_sc_out at EXEC end for ADD/SUB/SL/SR and drives sc_in; it is cleared by reset and start.
- Undefined: sc_in tied 0, no register.

Test Plan:
- Reset, start, instr 9'h003 (ADD imm 3) → FETCH cycle, then EXEC with alu_op=0, imm_exe=1, imm_out=8'h03, acc_we single pulse; pc 0→1.
- BEQ at pc=4: branch_en=1 → pc=6; branch_en=0 → pc=5. acc_we=reg_we=0 in both cases.
- JMP offset 5'b11101 at pc=10 → pc=7; same at pc=1 → pc=1022 (PC_W=10). At pc=1023, ADD → pc=0.
- LW with mem_ack on 3rd MEM_WAIT cycle → mem_re high 3 cycles, acc_we pulse on ack cycle. With no ack for 8 cycles → done=1, err=1, mem_re=0. Reset asserted mid-MEM_WAIT → all outputs 0 next cycle.
- instr opcode 13 → done=1, err=1, no strobes. HALT opcode → done=1, err=0. A subsequent start restarts at pc=0.
- CARRY_CHAIN_EN: ADD with alu_sc_out=1, then ADD → sc_in=1 during second EXEC. Without the macro, sc_in=0 always.
